// File: rtl/ripple_count_monitor_if.sv
// Signal bundle between a raw ripple-counter tap and its clk-domain monitor.
// The monitor attaches as slave; whatever drives the counter taps is the master.
interface ripple_count_monitor_if #(
  parameter int STAT_W = 8
);
  logic [3:0]        cnt_in;
  logic              mode_in;
  logic              clr_stats;
  logic [3:0]        count;
  logic              count_valid;
  logic              step_up;
  logic              step_down;
  logic              wrap;
  logic              skip_err;
  logic              dir_err;
  logic [STAT_W-1:0] wrap_cnt;
  logic [STAT_W-1:0] err_cnt;

  modport master (
    output cnt_in, mode_in, clr_stats,
    input  count, count_valid, step_up, step_down, wrap, skip_err, dir_err,
    input  wrap_cnt, err_cnt
  );

  modport slave (
    input  cnt_in, mode_in, clr_stats,
    output count, count_valid, step_up, step_down, wrap, skip_err, dir_err,
    output wrap_cnt, err_cnt
  );
endinterface

// File: rtl/ripple_count_monitor.sv
// Synchronizes and debounces a 4-bit async ripple count, classifies accepted steps, keeps stats.
// A settled input reaches count and pulses 2 + STABLE_CYCLES edges later; no backpressure.
module ripple_count_monitor #(
  parameter int STABLE_CYCLES = 2,
  parameter int STAT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ripple_count_monitor_if.slave bus
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    WARM0  = 2'd0,
    WARM1  = 2'd1,
    ACTIVE = 2'd2
  } phase_t;

  phase_t            phase_q;
  phase_t            phase_d;
  logic              filt_en;

  logic [3:0]        cnt_m;
  logic [3:0]        cnt_s;
  logic              mode_m;
  logic              mode_s;

  logic [3:0]        cand_q;
  logic [3:0]        cand_d;
  logic [3:0]        run_q;
  logic [3:0]        run_d;
  logic              accept;

  logic [3:0]        count_q;
  logic [3:0]        count_d;
  logic              valid_q;
  logic              valid_d;
  logic [3:0]        delta;
  logic              up_q;
  logic              up_d;
  logic              down_q;
  logic              down_d;
  logic              wrap_q;
  logic              wrap_d;
  logic              skip_q;
  logic              skip_d;
  logic              dir_q;
  logic              dir_d;

  logic [STAT_W-1:0] wrap_cnt_q;
  logic [STAT_W-1:0] err_cnt_q;

  // Warm-up sequencer: keeps the filter idle until the synchronizer holds real samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= WARM0;
    end else begin
      phase_q <= phase_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    filt_en = 1'b0;
    case (phase_q)
      WARM0:   phase_d = WARM1;
      WARM1:   phase_d = ACTIVE;
      ACTIVE:  filt_en = 1'b1;
      default: phase_d = WARM0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_m  <= 4'd0;
      cnt_s  <= 4'd0;
      mode_m <= 1'b0;
      mode_s <= 1'b0;
    end else begin
      cnt_m  <= bus.cnt_in;
      cnt_s  <= cnt_m;
      mode_m <= bus.mode_in;
      mode_s <= mode_m;
    end
  end

  // A new candidate also counts as an accept edge so STABLE_CYCLES = 1 still tracks changes.
  always_comb begin
    cand_d = 4'd0;
    run_d  = 4'd0;
    accept = 1'b0;
    if (filt_en) begin
      cand_d = cand_q;
      run_d  = run_q;
      if (cnt_s != cand_q) begin
        cand_d = cnt_s;
        run_d  = 4'd1;
      end else if (run_q < STABLE) begin
        run_d = run_q + 4'd1;
      end
      accept = (run_d == STABLE) && ((run_q != STABLE) || (cnt_s != cand_q));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= 4'd0;
      run_q  <= 4'd0;
    end else begin
      cand_q <= cand_d;
      run_q  <= run_d;
    end
  end

  assign delta = cand_d - count_q;

  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    up_d    = 1'b0;
    down_d  = 1'b0;
    wrap_d  = 1'b0;
    skip_d  = 1'b0;
    dir_d   = 1'b0;
    if (accept) begin
      if (!valid_q) begin
        count_d = cand_d;
        valid_d = 1'b1;
      end else if (cand_d != count_q) begin
        count_d = cand_d;
        if (delta == 4'd1) begin
          up_d   = 1'b1;
          dir_d  = ~mode_s;
          wrap_d = (count_q == 4'd15);
        end else if (delta == 4'd15) begin
          down_d = 1'b1;
          dir_d  = mode_s;
          wrap_d = (count_q == 4'd0);
        end else begin
          skip_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 4'd0;
      valid_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      wrap_q  <= 1'b0;
      skip_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      up_q    <= up_d;
      down_q  <= down_d;
      wrap_q  <= wrap_d;
      skip_q  <= skip_d;
      dir_q   <= dir_d;
    end
  end

  // Counters follow the registered pulses, so a clear in the pulse cycle suppresses that increment.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_stats) begin
      wrap_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (wrap_q && (wrap_cnt_q != '1)) begin
        wrap_cnt_q <= wrap_cnt_q + 1'b1;
      end
      if ((skip_q || dir_q) && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign bus.count       = count_q;
  assign bus.count_valid = valid_q;
  assign bus.step_up     = up_q;
  assign bus.step_down   = down_q;
  assign bus.wrap        = wrap_q;
  assign bus.skip_err    = skip_q;
  assign bus.dir_err     = dir_q;
  assign bus.wrap_cnt    = wrap_cnt_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor with STABLE_CYCLES = 2 and STAT_W = 2.
module tb_ripple_count_monitor;

  logic clk;
  logic rst;
  logic mon_clr;
  int   tests_run;
  int   tests_failed;
  int   n_up;
  int   n_down;
  int   n_wrap;
  int   n_skip;
  int   n_dir;
  int   n_down_dir;

  ripple_count_monitor_if #(.STAT_W(2)) bus ();

  ripple_count_monitor #(
    .STABLE_CYCLES(2),
    .STAT_W       (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_clr) begin
      n_up = 0; n_down = 0; n_wrap = 0; n_skip = 0; n_dir = 0; n_down_dir = 0;
    end else begin
      n_up       += int'(bus.step_up);
      n_down     += int'(bus.step_down);
      n_wrap     += int'(bus.wrap);
      n_skip     += int'(bus.skip_err);
      n_dir      += int'(bus.dir_err);
      n_down_dir += int'(bus.step_down & bus.dir_err);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] v);
    mon_clr       = 1'b1;
    rst           = 1'b1;
    bus.cnt_in    = v;
    bus.clr_stats = 1'b0;
    step(2);
    rst     = 1'b0;
    mon_clr = 1'b0;
    step(8);
  endtask

  task automatic test_reset;
    mon_clr       = 1'b1;
    rst           = 1'b1;
    bus.cnt_in    = 4'd5;
    bus.mode_in   = 1'b1;
    bus.clr_stats = 1'b0;
    step(3);
    tests_run++;
    if (bus.count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    tests_run++;
    if (bus.count_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %0b exp 0", bus.count_valid); end
    tests_run++;
    if ({bus.step_up, bus.step_down, bus.wrap, bus.skip_err, bus.dir_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses got %b exp 00000", {bus.step_up, bus.step_down, bus.wrap, bus.skip_err, bus.dir_err});
    end
    tests_run++;
    if ({bus.wrap_cnt, bus.err_cnt} !== 4'd0) begin
      tests_failed++; $display("FAIL reset_stats got %0d/%0d exp 0/0", bus.wrap_cnt, bus.err_cnt);
    end
    rst     = 1'b0;
    mon_clr = 1'b0;
    step(3);
    tests_run++;
    if (bus.count_valid !== 1'b0) begin tests_failed++; $display("FAIL early_valid edge3 got %0b exp 0", bus.count_valid); end
    step(1);
    tests_run++;
    if (bus.count_valid !== 1'b1) begin tests_failed++; $display("FAIL first_valid edge4 got %0b exp 1", bus.count_valid); end
    tests_run++;
    if (bus.count !== 4'd5) begin tests_failed++; $display("FAIL first_count got %0d exp 5", bus.count); end
    step(4);
    tests_run++;
    if (n_up + n_down + n_wrap + n_skip + n_dir != 0) begin
      tests_failed++; $display("FAIL first_accept_pulses got %0d exp 0", n_up + n_down + n_wrap + n_skip + n_dir);
    end
  endtask

  task automatic test_up_wrap;
    logic [3:0] seq [3];
    seq = '{4'd14, 4'd15, 4'd0};
    bus.mode_in = 1'b1;
    do_reset(4'd13);
    foreach (seq[i]) begin
      bus.cnt_in = seq[i];
      step(8);
    end
    tests_run++;
    if (n_up != 3) begin tests_failed++; $display("FAIL up_steps got %0d exp 3", n_up); end
    tests_run++;
    if (n_wrap != 1) begin tests_failed++; $display("FAIL up_wrap_pulses got %0d exp 1", n_wrap); end
    tests_run++;
    if (n_dir != 0 || n_skip != 0 || n_down != 0) begin
      tests_failed++; $display("FAIL up_no_errors got dir=%0d skip=%0d down=%0d exp 0", n_dir, n_skip, n_down);
    end
    tests_run++;
    if (bus.wrap_cnt !== 2'd1) begin tests_failed++; $display("FAIL up_wrap_cnt got %0d exp 1", bus.wrap_cnt); end
    tests_run++;
    if (bus.count !== 4'd0) begin tests_failed++; $display("FAIL up_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_down_dir_err;
    bus.mode_in = 1'b1;
    do_reset(4'd3);
    bus.cnt_in = 4'd2;
    step(8);
    tests_run++;
    if (n_down != 1) begin tests_failed++; $display("FAIL down_steps got %0d exp 1", n_down); end
    tests_run++;
    if (n_down_dir != 1 || n_dir != 1) begin
      tests_failed++; $display("FAIL down_dir_err got both=%0d dir=%0d exp 1/1", n_down_dir, n_dir);
    end
    tests_run++;
    if (bus.err_cnt !== 2'd1) begin tests_failed++; $display("FAIL down_err_cnt got %0d exp 1", bus.err_cnt); end
    tests_run++;
    if (bus.count !== 4'd2) begin tests_failed++; $display("FAIL down_count got %0d exp 2", bus.count); end
  endtask

  task automatic test_glitch;
    bus.mode_in = 1'b1;
    do_reset(4'd7);
    bus.cnt_in = 4'd6;
    step(1);
    bus.cnt_in = 4'd4;
    step(1);
    bus.cnt_in = 4'd8;
    step(8);
    tests_run++;
    if (n_up != 1) begin tests_failed++; $display("FAIL glitch_steps got %0d exp 1", n_up); end
    tests_run++;
    if (n_skip != 0 || n_down != 0) begin
      tests_failed++; $display("FAIL glitch_spurious got skip=%0d down=%0d exp 0", n_skip, n_down);
    end
    tests_run++;
    if (bus.count !== 4'd8) begin tests_failed++; $display("FAIL glitch_count got %0d exp 8", bus.count); end
  endtask

  task automatic test_skip_saturation;
    logic [3:0] seq [4];
    seq = '{4'd5, 4'd10, 4'd15, 4'd4};
    bus.mode_in = 1'b1;
    do_reset(4'd0);
    foreach (seq[i]) begin
      bus.cnt_in = seq[i];
      step(8);
    end
    tests_run++;
    if (n_skip != 4) begin tests_failed++; $display("FAIL skip_pulses got %0d exp 4", n_skip); end
    tests_run++;
    if (bus.err_cnt !== 2'd3) begin tests_failed++; $display("FAIL skip_err_cnt_sat got %0d exp 3", bus.err_cnt); end
    tests_run++;
    if (n_wrap != 0 || n_up != 0 || n_down != 0) begin
      tests_failed++; $display("FAIL skip_no_steps got wrap=%0d up=%0d down=%0d exp 0", n_wrap, n_up, n_down);
    end
    tests_run++;
    if (bus.count !== 4'd4) begin tests_failed++; $display("FAIL skip_count got %0d exp 4", bus.count); end
  endtask

  task automatic test_clr_and_midrun_reset;
    bit found;
    bus.mode_in = 1'b1;
    do_reset(4'd15);
    bus.cnt_in = 4'd0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step(1);
      if (bus.wrap === 1'b1) begin
        found         = 1'b1;
        bus.clr_stats = 1'b1;
        step(1);
        bus.clr_stats = 1'b0;
      end
    end
    tests_run++;
    if (!found) begin tests_failed++; $display("FAIL clr_wrap_seen got 0 exp 1"); end
    tests_run++;
    if (bus.wrap_cnt !== 2'd0) begin tests_failed++; $display("FAIL clr_wins got %0d exp 0", bus.wrap_cnt); end
    step(2);
    tests_run++;
    if (bus.wrap_cnt !== 2'd0) begin tests_failed++; $display("FAIL clr_hold got %0d exp 0", bus.wrap_cnt); end

    bus.cnt_in = 4'd5;
    step(8);
    tests_run++;
    if (bus.err_cnt !== 2'd1) begin tests_failed++; $display("FAIL midrun_pre_err got %0d exp 1", bus.err_cnt); end
    bus.cnt_in = 4'd6;
    step(3);
    rst = 1'b1;
    step(1);
    tests_run++;
    if (bus.count !== 4'd0 || bus.count_valid !== 1'b0) begin
      tests_failed++; $display("FAIL midrun_count got %0d/%0b exp 0/0", bus.count, bus.count_valid);
    end
    tests_run++;
    if ({bus.step_up, bus.step_down, bus.wrap, bus.skip_err, bus.dir_err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL midrun_pulses got %b exp 00000", {bus.step_up, bus.step_down, bus.wrap, bus.skip_err, bus.dir_err});
    end
    tests_run++;
    if ({bus.wrap_cnt, bus.err_cnt} !== 4'd0) begin
      tests_failed++; $display("FAIL midrun_stats got %0d/%0d exp 0/0", bus.wrap_cnt, bus.err_cnt);
    end
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    mon_clr       = 1'b1;
    rst           = 1'b1;
    bus.cnt_in    = 4'd0;
    bus.mode_in   = 1'b1;
    bus.clr_stats = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_dir_err();
    test_glitch();
    test_skip_saturation();
    test_clr_and_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
